mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory stage between EX and WB in the single-cycle core.
- Takes the EX-computed address plus rs2 store data and runs a req/ready handshake with the external data memory.
- Does byte/halfword lane steering and sign extension, and produces the aligned data_mem_read_data that WB consumes.
- Stalls the core (PC and register writes held) while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: REQ-state cycles without mem_ready before the access aborts with bus_error; minimum 1.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- EX_result  input  32  byte address of the access
- rs2_data  input  32  store data, unaligned; byte/half taken from low bits
- ID_memread  input  1  instruction is a load
- ID_memwrite  input  1  instruction is a store
- ID_funct3  input  3  access size and signedness
- mem_req  output  1  request valid to data memory
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address {EX_result[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables
- mem_ready  input  1  memory completes the request this cycle
- mem_rdata  input  32  read word, valid with mem_ready
- data_mem_read_data  output  32  extended load result to WB
- stall  output  1  hold PC/regfile this cycle
- misaligned  output  1  one-cycle fault pulse: misaligned address or illegal funct3
- bus_error  output  1  one-cycle fault pulse: timeout

Behaviour:
- Access condition: access = ID_memread | ID_memwrite.
- Fault condition: fault = (memread & memwrite) | illegal funct3 (load: 011/110/111; store: anything other than 000/001/010) | half with addr[0]=1 | word with addr[1:0]≠0.
- FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - access & !fault: stall=1, latch we/addr/wdata/wstrb/funct3/addr[1:0], go to REQ.
  - access & fault: misaligned=1 for this cycle, stall=0, no request issued, data_mem_read_data=0, stay in IDLE.
  - no access: stall=0.
- REQ:
  - mem_req=1 and stall=1. mem_we/addr/wdata/wstrb come from registers and hold stable until mem_ready.
  - On mem_ready: capture the extended load result (store: 0), go to DONE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES-1 without ready: bus_error pulses on the DONE cycle, captured data=0, go to DONE.
- DONE:
  - stall=0. data_mem_read_data holds the captured value; the core retires the instruction at this edge.
  - Go to IDLE unconditionally. Do not re-evaluate access in DONE; this prevents a double issue.
- Latency: best case 3 cycles per access (IDLE, one REQ, DONE). Non-memory instructions see zero added cycles.
- Load extension, k = addr[1:0]:
  - LB/LBU (000/100): byte k, sign- or zero-extended.
  - LH/LHU (001/101): half k[1], sign- or zero-extended.
  - LW (010): whole word.
- Store lanes:
  - SB: wstrb = 4'b0001<<k, wdata = {4{rs2[7:0]}}.
  - SH: wstrb = k[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = rs2.
- Reset values: state=IDLE, counter=0, captured data=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, bus_error=0. stall and misaligned are combinational from IDLE inputs.
- Reset mid-REQ: mem_req drops at the next edge; any later mem_ready is ignored, and the memory discards a request withdrawn by reset.
- mem_ready is ignored in IDLE and DONE.
- data_mem_read_data outside DONE is 0.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - mem_state_t enum: IDLE, REQ, DONE.
  - Width constant XLEN=32.
- One sub-module, mem_load_align: purely combinational (rdata, funct3, offset) -> 32-bit extended result. Reused by the bench scoreboard.
- The FSM, counter and store steering stay in mem_access_unit.

Test Plan:
- LW, addr 0x100, ready on 1st REQ cycle, rdata 0xDEADBEEF -> mem_addr 0x100, stall high 2 cycles, DONE data 0xDEADBEEF.
- LB/LBU, addr 0x103, rdata 0x80FF1234 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB, addr 0x201, rs2 0x000000A5 -> mem_we=1, wstrb 0010, wdata 0xA5A5A5A5, mem_addr 0x200. SH at 0x202 -> wstrb 1100.
- LW at 0x102, or LH at 0x101 -> misaligned pulses 1 cycle, mem_req never asserts, stall 0, data 0.
- LW with mem_ready held low (TIMEOUT_CYCLES=16) -> 16 REQ cycles, bus_error pulse in DONE, data 0. Then a back-to-back LW with ready after 3 cycles completes normally.
- rst asserted in the 2nd REQ cycle, then mem_ready pulsed -> next edge: state IDLE, mem_req 0, stall 0, ready ignored, no data captured.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings,
// FSM state type and datapath width.
package mem_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } mem_state_t;
endpackage

// File: rtl/mem_load_align.sv
// Purpose: select the addressed byte/half of a read word and sign/zero extend it.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        result = '0;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            F3_W:    result = rdata;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Purpose: EX->WB data-memory stage; req/ready handshake, store lane steering, load extension.
// Latency: 3 cycles per access (IDLE, >=1 REQ, DONE); non-memory instructions add none.
// Backpressure: stall held while the request is outstanding; aborts with bus_error after TIMEOUT_CYCLES.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] EX_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ID_memread,
    input  logic            ID_memwrite,
    input  logic [2:0]      ID_funct3,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] data_mem_read_data,
    output logic            stall,
    output logic            misaligned,
    output logic            bus_error
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t      state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [XLEN-1:0] rdata_q;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;
    logic [XLEN-1:0] load_ext;

    logic            access;
    logic            illegal_f3;
    logic            misalign_addr;
    logic            fault;
    logic [3:0]      wstrb_nxt;
    logic [XLEN-1:0] wdata_nxt;

    always_comb begin
        access     = ID_memread | ID_memwrite;
        illegal_f3 = 1'b0;
        if (ID_memread && (ID_funct3 == 3'b011 || ID_funct3 == 3'b110 || ID_funct3 == 3'b111))
            illegal_f3 = 1'b1;
        if (ID_memwrite && !(ID_funct3 == F3_B || ID_funct3 == F3_H || ID_funct3 == F3_W))
            illegal_f3 = 1'b1;
        misalign_addr = (ID_funct3[1:0] == 2'b01 && EX_result[0]) ||
                        (ID_funct3[1:0] == 2'b10 && EX_result[1:0] != 2'b00);
        fault = (ID_memread & ID_memwrite) | illegal_f3 | misalign_addr;

        case (ID_funct3[1:0])
            2'b00: begin
                wstrb_nxt = 4'b0001 << EX_result[1:0];
                wdata_nxt = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                wstrb_nxt = EX_result[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{rs2_data[15:0]}};
            end
            default: begin
                wstrb_nxt = 4'b1111;
                wdata_nxt = rs2_data;
            end
        endcase
    end

    assign stall              = (state == IDLE && access && !fault) || (state == REQ);
    assign misaligned         = (state == IDLE) && access && fault;
    assign data_mem_read_data = (state == DONE) ? rdata_q : '0;

    mem_load_align u_load_align (
        .rdata  (mem_rdata),
        .funct3 (funct3_q),
        .offset (offset_q),
        .result (load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            rdata_q   <= '0;
            funct3_q  <= '0;
            offset_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus_error <= 1'b0;
                    if (access && !fault) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= ID_memwrite;
                        mem_addr  <= {EX_result[31:2], 2'b00};
                        mem_wdata <= wdata_nxt;
                        mem_wstrb <= ID_memwrite ? wstrb_nxt : 4'b0000;
                        funct3_q  <= ID_funct3;
                        offset_q  <= EX_result[1:0];
                        tmo_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        rdata_q <= mem_we ? '0 : load_ext;
                        state   <= DONE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        rdata_q   <= '0;
                        bus_error <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Core retires here; access is not re-evaluated to avoid a double issue.
                    bus_error <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults, timeout and reset mid-request.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] EX_result = '0;
    logic [31:0] rs2_data = '0;
    logic        ID_memread = 1'b0;
    logic        ID_memwrite = 1'b0;
    logic [2:0]  ID_funct3 = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] data_mem_read_data;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .EX_result          (EX_result),
        .rs2_data           (rs2_data),
        .ID_memread         (ID_memread),
        .ID_memwrite        (ID_memwrite),
        .ID_funct3          (ID_funct3),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wstrb          (mem_wstrb),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata),
        .data_mem_read_data (data_mem_read_data),
        .stall              (stall),
        .misaligned         (misaligned),
        .bus_error          (bus_error)
    );

    always #5 clk = ~clk;

    // Result of one driven instruction, as observed at the DUT pins.
    logic [31:0] r_data, r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we, r_berr, r_misal;
    int          r_stall, r_req;

    // Presents one instruction from IDLE and runs it until stall drops; ready_after<0 means never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int ready_after);
        logic done;
        done = 1'b0;
        r_data = '0; r_addr = '0; r_wdata = '0; r_wstrb = '0;
        r_we = 1'b0; r_berr = 1'b0; r_misal = 1'b0; r_stall = 0; r_req = 0;
        ID_memread = rd; ID_memwrite = wr; ID_funct3 = f3; EX_result = addr; rs2_data = rs2;
        #1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (misaligned) r_misal = 1'b1;
            if (!stall) begin
                r_data = data_mem_read_data;
                r_berr = bus_error;
                done = 1'b1;
                break;
            end
            r_stall++;
            if (mem_req) begin
                r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb; r_we = mem_we;
                if (ready_after >= 0 && r_req == ready_after) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
                r_req++;
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = '0;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL access_completion got=stuck_stalled exp=stall_drop");
        end
        ID_memread = 1'b0; ID_memwrite = 1'b0; ID_funct3 = '0; EX_result = '0; rs2_data = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_mem_wstrb got=%b exp=0000", mem_wstrb); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error got=%b exp=0", bus_error); end
        checks++; if (data_mem_read_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_mem_read_data); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checks++; if (r_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", r_addr); end
        checks++; if (r_we !== 1'b0) begin failures++; $display("FAIL lw_we got=%b exp=0", r_we); end
        checks++; if (r_stall != 2) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=2", r_stall); end
        checks++; if (r_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", r_data); end
        checks++; if (data_mem_read_data !== 32'h0) begin failures++; $display("FAIL lw_data_after_done got=%h exp=0", data_mem_read_data); end
    endtask

    task automatic test_load_extend;
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
        checks++; if (r_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", r_data); end
        checks++; if (r_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", r_addr); end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0);
        checks++; if (r_data !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", r_data); end
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0);
        checks++; if (r_data !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_data got=%h exp=ffff80ff", r_data); end
        run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF9234, 0);
        checks++; if (r_data !== 32'h00009234) begin failures++; $display("FAIL lhu_data got=%h exp=00009234", r_data); end
        run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 0);
        checks++; if (r_data !== 32'h00000012) begin failures++; $display("FAIL lb_byte1_data got=%h exp=00000012", r_data); end
    endtask

    task automatic test_store;
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 0);
        checks++; if (r_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", r_we); end
        checks++; if (r_wstrb !== 4'b0010) begin failures++; $display("FAIL sb_wstrb got=%b exp=0010", r_wstrb); end
        checks++; if (r_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", r_wdata); end
        checks++; if (r_addr !== 32'h200) begin failures++; $display("FAIL sb_addr got=%h exp=00000200", r_addr); end
        checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL sb_data got=%h exp=0", r_data); end
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 0);
        checks++; if (r_wstrb !== 4'b1100) begin failures++; $display("FAIL sh_wstrb got=%b exp=1100", r_wstrb); end
        checks++; if (r_wdata !== 32'hBEEFBEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", r_wdata); end
        run_access(1'b0, 1'b1, 3'b010, 32'h204, 32'h11223344, 32'h0, 0);
        checks++; if (r_wstrb !== 4'b1111) begin failures++; $display("FAIL sw_wstrb got=%b exp=1111", r_wstrb); end
        checks++; if (r_wdata !== 32'h11223344) begin failures++; $display("FAIL sw_wdata got=%h exp=11223344", r_wdata); end
        checks++; if (r_addr !== 32'h204) begin failures++; $display("FAIL sw_addr got=%h exp=00000204", r_addr); end
    endtask

    task automatic test_misaligned;
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        checks++; if (r_misal !== 1'b1) begin failures++; $display("FAIL lw_mis_pulse got=%b exp=1", r_misal); end
        checks++; if (r_req != 0) begin failures++; $display("FAIL lw_mis_req got=%0d exp=0", r_req); end
        checks++; if (r_stall != 0) begin failures++; $display("FAIL lw_mis_stall got=%0d exp=0", r_stall); end
        checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL lw_mis_data got=%h exp=0", r_data); end
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_after got=%b exp=0", misaligned); end
        run_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        checks++; if (r_misal !== 1'b1 || r_req != 0) begin failures++; $display("FAIL lh_mis got=mis%b/req%0d exp=mis1/req0", r_misal, r_req); end
        run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        checks++; if (r_misal !== 1'b1 || r_req != 0) begin failures++; $display("FAIL illegal_f3 got=mis%b/req%0d exp=mis1/req0", r_misal, r_req); end
        run_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        checks++; if (r_misal !== 1'b1 || r_req != 0) begin failures++; $display("FAIL store_f3 got=mis%b/req%0d exp=mis1/req0", r_misal, r_req); end
        run_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        checks++; if (r_misal !== 1'b1 || r_req != 0) begin failures++; $display("FAIL rd_and_wr got=mis%b/req%0d exp=mis1/req0", r_misal, r_req); end
    endtask

    task automatic test_timeout_back_to_back;
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, -1);
        checks++; if (r_req != 16) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=16", r_req); end
        checks++; if (r_berr !== 1'b1) begin failures++; $display("FAIL timeout_bus_error got=%b exp=1", r_berr); end
        checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL timeout_data got=%h exp=0", r_data); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL bus_error_pulse got=%b exp=0", bus_error); end
        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 3);
        checks++; if (r_req != 4) begin failures++; $display("FAIL b2b_req_cycles got=%0d exp=4", r_req); end
        checks++; if (r_data !== 32'h12345678) begin failures++; $display("FAIL b2b_data got=%h exp=12345678", r_data); end
        checks++; if (r_berr !== 1'b0) begin failures++; $display("FAIL b2b_bus_error got=%b exp=0", r_berr); end
    endtask

    task automatic test_reset_mid_req;
        ID_memread = 1'b1; ID_funct3 = 3'b010; EX_result = 32'h300;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstreq_first_req got=%b exp=1", mem_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ID_memread = 1'b0; ID_funct3 = '0; EX_result = '0;
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstreq_req got=%b exp=0", mem_req); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstreq_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = '0;
        checks++; if (data_mem_read_data !== 32'h0) begin failures++; $display("FAIL rstreq_data got=%h exp=0", data_mem_read_data); end
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rstreq_idle got=req%b/stall%b exp=req0/stall0", mem_req, stall); end
        run_access(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 32'hA1B2C3D4, 1);
        checks++; if (r_data !== 32'hA1B2C3D4) begin failures++; $display("FAIL rstreq_recover got=%h exp=a1b2c3d4", r_data); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misaligned();
        test_timeout_back_to_back();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
